// File: rtl/reg_mem.sv
// rtl/reg_mem.sv - 8x16 decode-stage register file with two async read ports and one priority-muxed write port
module reg_mem #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int LINK_REG = 7,
  parameter int PC_INC   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(NUM_REGS)-1:0] ReadReg1,
  input  logic [$clog2(NUM_REGS)-1:0] ReadReg2,
  input  logic [$clog2(NUM_REGS)-1:0] WriteReg,
  input  logic [DATA_W-1:0]           WriteData,
  input  logic [DATA_W-1:0]           Imm,
  input  logic [DATA_W-1:0]           PC,
  input  logic                        LBI,
  input  logic                        Link,
  output logic [DATA_W-1:0]           Reg1Data,
  output logic [DATA_W-1:0]           Reg2Data
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;

  // Select the single write performed every cycle: link beats LBI beats normal write-back
  always_comb begin
    w_wr_addr = WriteReg;
    w_wr_data = WriteData;
    if (Link) begin
      w_wr_addr = ADDR_W'(LINK_REG);
      w_wr_data = PC + DATA_W'(PC_INC);
    end else if (LBI) begin
      w_wr_addr = ReadReg1;
      w_wr_data = Imm;
    end
  end

  // Register storage: reset clears everything, otherwise exactly one entry is written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_regs[w_wr_addr] <= w_wr_data;
    end
  end

  // Zero-latency reads with no bypass: a write shows up only after its edge
  assign Reg1Data = r_regs[ReadReg1];
  assign Reg2Data = r_regs[ReadReg2];

endmodule

// File: tb/tb_reg_mem.sv
// tb/tb_reg_mem.sv - randomized self-checking bench for reg_mem against an array reference model
`timescale 1ns/1ps
module tb_reg_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ReadReg1, ReadReg2, WriteReg;
  logic [15:0] WriteData, Imm, PC;
  logic        LBI, Link;
  logic [15:0] Reg1Data, Reg2Data;

  int errors = 0;
  int checks = 0;
  logic [15:0] model [8];

  always #20 clk = ~clk;

  reg_mem dut (
    .clk       (clk),
    .rst       (rst),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .Imm       (Imm),
    .PC        (PC),
    .LBI       (LBI),
    .Link      (Link),
    .Reg1Data  (Reg1Data),
    .Reg2Data  (Reg2Data)
  );

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge; the model applies the architectural rule for the inputs held across it
  task automatic clock_edge();
    logic [15:0] link_val;
    @(posedge clk);
    #1;
    link_val = 16'((32'(PC) + 2) % 65536);
    if (rst) begin
      for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    end else if (Link) begin
      model[7] = link_val;
    end else if (LBI) begin
      model[ReadReg1] = Imm;
    end else begin
      model[WriteReg] = WriteData;
    end
  endtask

  // Read every register on both ports between edges, then restore the read addresses
  task automatic sweep(input string tag);
    logic [2:0] s1, s2;
    s1 = ReadReg1;
    s2 = ReadReg2;
    for (int a = 0; a < 8; a++) begin
      ReadReg1 = 3'(a);
      ReadReg2 = 3'(7 - a);
      #1;
      check_val({tag, "_p1"}, Reg1Data, model[a]);
      check_val({tag, "_p2"}, Reg2Data, model[7 - a]);
    end
    ReadReg1 = s1;
    ReadReg2 = s2;
    #1;
  endtask

  initial begin
    rst = 1'b1; ReadReg1 = '0; ReadReg2 = '0; WriteReg = '0;
    WriteData = '0; Imm = '0; PC = '0; LBI = 1'b0; Link = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 16'hDEAD;

    // Reset held for two edges
    clock_edge();
    clock_edge();
    for (int a = 0; a < 8; a++) begin
      ReadReg1 = 3'(a);
      ReadReg2 = 3'(a);
      #1;
      check_val("reset_r1", Reg1Data, 16'h0000);
      check_val("reset_r2", Reg2Data, 16'h0000);
    end
    rst = 1'b0;

    // Fill Ri <- i and read back in pairs
    for (int i = 0; i < 8; i++) begin
      WriteReg = 3'(i);
      WriteData = 16'(i);
      clock_edge();
    end
    WriteReg = 3'd0;
    WriteData = 16'd0;
    for (int k = 0; k < 4; k++) begin
      ReadReg1 = 3'(2 * k);
      ReadReg2 = 3'(2 * k + 1);
      #1;
      check_val("fill_r1", Reg1Data, 16'(2 * k));
      check_val("fill_r2", Reg2Data, 16'(2 * k + 1));
    end

    // LBI writes Imm into Rs
    ReadReg1 = 3'd6; ReadReg2 = 3'd0; Imm = 16'd1; LBI = 1'b1;
    clock_edge();
    check_val("lbi_r6", Reg1Data, 16'd1);
    check_val("lbi_r0", Reg2Data, 16'd0);

    // Link outranks LBI
    ReadReg1 = 3'd7; PC = 16'd10; Link = 1'b1;
    clock_edge();
    check_val("link_prio", Reg1Data, 16'd12);

    // Link address wraps
    PC = 16'hFFFF;
    clock_edge();
    check_val("link_wrap", Reg1Data, 16'h0001);
    Link = 1'b0; LBI = 1'b0;

    // Same-register read/write: old before the edge, new after
    ReadReg1 = 3'd3; WriteReg = 3'd3; WriteData = 16'hABCD;
    #1;
    check_val("rw_old", Reg1Data, 16'd3);
    clock_edge();
    check_val("rw_new", Reg1Data, 16'hABCD);

    // Reset mid-operation overrides the pending write
    rst = 1'b1;
    clock_edge();
    rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      ReadReg1 = 3'(a);
      #1;
      check_val("rst_mid", Reg1Data, 16'h0000);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      rst       = ($urandom_range(0, 39) == 0);
      Link      = ($urandom_range(0, 3) == 0);
      LBI       = ($urandom_range(0, 3) == 0);
      ReadReg1  = 3'($urandom_range(0, 7));
      ReadReg2  = 3'($urandom_range(0, 7));
      WriteReg  = 3'($urandom_range(0, 7));
      WriteData = 16'($urandom);
      Imm       = 16'($urandom);
      PC        = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      #1;
      check_val("rnd_pre_r1", Reg1Data, model[ReadReg1]);
      check_val("rnd_pre_r2", Reg2Data, model[ReadReg2]);
      clock_edge();
      check_val("rnd_post_r1", Reg1Data, model[ReadReg1]);
      check_val("rnd_post_r2", Reg2Data, model[ReadReg2]);
      if (n % 50 == 49) sweep("rnd_sweep");
    end
    rst = 1'b0;
    sweep("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
